// File: rtl/dilithium_vy_sequencer.sv
// VERIFY-job sequencer for one dilithium core: fetches pk/sig/msg words from a buffer and streams them.
// Optional core_start-to-result cycle counter enabled by defining DILITHIUM_SEQ_CYCLES_EN.

// state      | meaning
// S_IDLE     | waiting for a job request (req_ready=1)
// S_START    | core_start pulse, first buffer read issued
// S_STREAM   | fetching words and streaming them to the core
// S_WAIT_RES | all words accepted, waiting for the core result
// S_DONE     | one-cycle done pulse
module dilithium_vy_sequencer #(
  parameter int W  = 64,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_base,
  input  logic [2:0]    req_sec_lvl,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          core_start,
  output logic [1:0]    core_mode,
  output logic [2:0]    core_sec_lvl,
  output logic          core_valid_i,
  output logic [W-1:0]  core_data_i,
  input  logic          core_ready_i,
  input  logic          core_valid_o,
  input  logic [W-1:0]  core_data_o,
  output logic          core_ready_o,
  output logic          done,
  output logic          accept,
  output logic          err,
  output logic [31:0]   cycles
);

  localparam logic [1:0] VERIFY_MODE = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT_RES, S_DONE} state_t;
  typedef enum logic [3:0] {F_RHO, F_C, F_Z, F_T1, F_MLEN, F_MLEN_WAIT, F_MSG, F_H, F_END} field_t;

  state_t        state, state_nxt;
  field_t        field;
  logic [29:0]   fcnt;
  logic [AW-1:0] addr;
  logic [2:0]    sec_lvl_r;
  logic          accept_r, err_r;
  logic          rd_valid;
  logic [W-1:0]  fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    occ;
  logic [2:0]    pending;
  logic [29:0]   z_len, t1_len, h_len, msg_words;
  logic          legal_lvl, fetch_ok, fifo_empty, fire, push, pop, last_word;
  logic          unused_core_data;

  assign legal_lvl = (req_sec_lvl == 3'b010) || (req_sec_lvl == 3'b011) || (req_sec_lvl == 3'b101);
  assign unused_core_data = ^core_data_o[W-1:1];

  always_comb begin
    z_len  = 30'd288;
    t1_len = 30'd160;
    h_len  = 30'd11;
    case (sec_lvl_r)
      3'b011: begin z_len = 30'd400; t1_len = 30'd240; h_len = 30'd8;  end
      3'b101: begin z_len = 30'd560; t1_len = 30'd320; h_len = 30'd11; end
      default: ;
    endcase
  end

  // mlen is a byte count; the message occupies ceil(mlen/8) words
  assign msg_words = 30'(({1'b0, rd_data[31:0]} + 33'd7) >> 3);

  // Reads return after exactly one cycle, so at most one read is ever in flight
  assign pending    = {1'b0, occ} + {2'b00, rd_valid};
  assign fetch_ok   = ((state == S_START) || (state == S_STREAM)) &&
                      (field != F_MLEN_WAIT) && (field != F_END);
  assign rd_en      = fetch_ok && (pending < 3'd2);
  assign rd_addr    = addr;

  assign fifo_empty   = (occ == 2'd0);
  assign core_valid_i = (state == S_STREAM) && (!fifo_empty || rd_valid);
  assign core_data_i  = !core_valid_i ? '0 : (fifo_empty ? rd_data : fifo_mem[rd_ptr]);
  assign fire         = core_valid_i && core_ready_i;
  // Returning data bypasses the FIFO only when it is empty and the core takes it right away
  assign push         = rd_valid && !(fifo_empty && core_ready_i);
  assign pop          = fire && !fifo_empty;
  assign last_word    = fire && (field == F_END) && (pending == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    core_start   = 1'b0;
    core_ready_o = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = legal_lvl ? S_START : S_DONE;
      end
      S_START: begin
        core_start = 1'b1;
        state_nxt  = S_STREAM;
      end
      S_STREAM: begin
        if (last_word) state_nxt = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        core_ready_o = 1'b1;
        if (core_valid_o) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch side: field tracker with a per-field down-counter, terminal count at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field <= F_END;
      fcnt  <= '0;
      addr  <= '0;
    end else if (state == S_IDLE && req_valid) begin
      field <= F_RHO;
      fcnt  <= 30'd4;
      addr  <= req_base;
    end else if (rd_en) begin
      addr <= addr + AW'(1);
      if (fcnt == 30'd1) begin
        case (field)
          F_RHO:   begin field <= F_C;    fcnt <= 30'd4;  end
          F_C:     begin field <= F_Z;    fcnt <= z_len;  end
          F_Z:     begin field <= F_T1;   fcnt <= t1_len; end
          F_T1:    begin field <= F_MLEN; fcnt <= 30'd1;  end
          F_MLEN:  field <= F_MLEN_WAIT;
          F_MSG:   begin field <= F_H;    fcnt <= h_len;  end
          default: field <= F_END;
        endcase
      end else begin
        fcnt <= fcnt - 30'd1;
      end
    end else if (field == F_MLEN_WAIT) begin
      // rd_data holds the mlen word during this single bubble cycle
      if (msg_words == 30'd0) begin
        field <= F_H;
        fcnt  <= h_len;
      end else begin
        field <= F_MSG;
        fcnt  <= msg_words;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (state == S_IDLE) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_lvl_r <= '0;
      accept_r  <= 1'b0;
      err_r     <= 1'b0;
    end else if (state == S_IDLE && req_valid) begin
      sec_lvl_r <= req_sec_lvl;
      accept_r  <= 1'b0;
      err_r     <= !legal_lvl;
    end else if (state == S_WAIT_RES && core_valid_o) begin
      accept_r  <= ~core_data_o[0];
    end
  end

  assign core_mode    = VERIFY_MODE;
  assign core_sec_lvl = sec_lvl_r;
  assign accept       = accept_r;
  assign err          = err_r;

`ifdef DILITHIUM_SEQ_CYCLES_EN
  logic [31:0] cyc_cnt;

  // Counts every cycle after core_start up to and including the capture cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if ((state == S_IDLE && req_valid) || core_start) begin
      cyc_cnt <= '0;
    end else if ((state == S_STREAM || state == S_WAIT_RES) && cyc_cnt != 32'hFFFF_FFFF) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign cycles = cyc_cnt;
`else
  assign cycles = '0;
`endif

endmodule

// File: tb/tb_dilithium_vy_sequencer.sv
// Self-checking bench for dilithium_vy_sequencer: job table plus reset and cycle-count sequences.
module tb_dilithium_vy_sequencer;
  localparam int W  = 64;
  localparam int AW = 16;

  logic          clk, rst_n;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_base;
  logic [2:0]    req_sec_lvl;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          core_start;
  logic [1:0]    unused_core_mode;
  logic [2:0]    core_sec_lvl;
  logic          core_valid_i, core_ready_i;
  logic [W-1:0]  core_data_i;
  logic          core_valid_o, core_ready_o;
  logic [W-1:0]  core_data_o;
  logic          done, accept, err;
  logic [31:0]   cycles;

  dilithium_vy_sequencer #(.W(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base), .req_sec_lvl(req_sec_lvl),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .core_start(core_start), .core_mode(unused_core_mode), .core_sec_lvl(core_sec_lvl),
    .core_valid_i(core_valid_i), .core_data_i(core_data_i), .core_ready_i(core_ready_i),
    .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_ready_o(core_ready_o),
    .done(done), .accept(accept), .err(err), .cycles(cycles)
  );

  typedef struct {
    logic [2:0]    lvl;
    logic [31:0]   mlen;
    logic [AW-1:0] base;
    logic [W-1:0]  res;
    bit            rnd;
    int            delay;
    int            words;
    bit            acc;
    bit            err;
  } job_t;

  logic [W-1:0]  bufmem [65536];
  logic [W-1:0]  exp_q [$];
  logic [AW-1:0] exp_addr, fill_addr;
  int  total = 0, bad = 0, cyc = 0;
  int  rd_cnt, stream_cnt, start_cnt, done_cnt;
  int  req_cyc, start_cyc, first_rd, first_val, last_fire, cap_cyc, done_cyc;
  bit  rdy_mode = 1'b0;
  logic got_acc, got_err;
  logic [31:0] got_cyc;
  logic [2:0]  got_lvl;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [W-1:0] prev_d = '0;
  job_t jobs [8];

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  always @(posedge clk) if (rd_en) rd_data <= bufmem[rd_addr];

  initial begin
    core_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      core_ready_i = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int z_words(input logic [2:0] l);
    return (l == 3'b011) ? 400 : (l == 3'b101) ? 560 : 288;
  endfunction
  function automatic int t1_words(input logic [2:0] l);
    return (l == 3'b011) ? 240 : (l == 3'b101) ? 320 : 160;
  endfunction
  function automatic int h_words(input logic [2:0] l);
    return (l == 3'b011) ? 8 : 11;
  endfunction

  // Output monitor and stream scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (req_valid && req_ready) req_cyc = cyc;
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk("rd_addr", 64'(rd_addr), 64'(exp_addr));
        exp_addr = exp_addr + 16'd1;
        rd_cnt++;
      end
      if (core_start) begin start_cnt++; start_cyc = cyc; end
      if (prev_v && !prev_r) begin
        chk("stall_valid_hold", 64'(core_valid_i), 64'd1);
        chk("stall_data_hold", core_data_i, prev_d);
      end
      if (core_valid_i) begin
        if (first_val < 0) first_val = cyc;
        if (core_ready_i) begin
          stream_cnt++;
          last_fire = cyc;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_word: got %0h want no word", core_data_i);
          end else begin
            chk("stream_word", core_data_i, exp_q.pop_front());
          end
        end
      end
      if (core_valid_o && core_ready_o) cap_cyc = cyc;
      if (done) begin
        done_cnt++; done_cyc = cyc;
        got_acc = accept; got_err = err; got_cyc = cycles; got_lvl = core_sec_lvl;
      end
      prev_v = core_valid_i; prev_r = core_ready_i; prev_d = core_data_i;
    end
  end

  task automatic put_word(input logic [W-1:0] v);
    bufmem[fill_addr] = v;
    exp_q.push_back(v);
    fill_addr = fill_addr + 16'd1;
  endtask

  task automatic put_rand(input int n);
    for (int i = 0; i < n; i++) put_word({$urandom(), $urandom()});
  endtask

  task automatic launch_job(input job_t j);
    rd_cnt = 0; stream_cnt = 0; start_cnt = 0; done_cnt = 0;
    req_cyc = -1; start_cyc = -1; first_rd = -1; first_val = -1; last_fire = -1;
    cap_cyc = -1; done_cyc = -1;
    exp_q.delete();
    if (!j.err) begin
      fill_addr = j.base;
      put_rand(4); put_rand(4); put_rand(z_words(j.lvl)); put_rand(t1_words(j.lvl));
      put_word({$urandom(), j.mlen});
      put_rand((int'(j.mlen) + 7) / 8);
      put_rand(h_words(j.lvl));
    end
    exp_addr = j.base;
    rdy_mode = j.rnd;
    @(posedge clk); #1;
    req_valid = 1'b1; req_base = j.base; req_sec_lvl = j.lvl;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_job(input job_t j, input string tag);
    int  hold = 0;
    bit  ok = 1'b0;
    logic [63:0] exp_c;
    for (int n = 0; n < 6000; n++) begin
      if (done_cnt != 0) begin ok = 1'b1; break; end
      if (core_ready_o) begin
        if (hold >= j.delay) begin core_valid_o = 1'b1; core_data_o = j.res; end
        else hold++;
      end else begin
        core_valid_o = 1'b0;
      end
      @(posedge clk); #1;
    end
    core_valid_o = 1'b0;
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "_accept_hold"}, 64'(accept), 64'(j.acc));
    chk({tag, "_accept"}, 64'(got_acc), 64'(j.acc));
    chk({tag, "_err"}, 64'(got_err), 64'(j.err));
    chk({tag, "_sec_lvl"}, 64'(got_lvl), 64'(j.lvl));
    chk({tag, "_rd_count"}, 64'(rd_cnt), 64'(j.words));
    chk({tag, "_stream_count"}, 64'(stream_cnt), 64'(j.words));
    chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
`ifdef DILITHIUM_SEQ_CYCLES_EN
    exp_c = j.err ? 64'd0 : 64'(cap_cyc - start_cyc);
`else
    exp_c = 64'd0;
`endif
    chk({tag, "_cycles"}, 64'(got_cyc), exp_c);
    if (j.err) begin
      chk({tag, "_no_start"}, 64'(start_cnt), 64'd0);
      chk({tag, "_done_lat"}, 64'(done_cyc - req_cyc), 64'd1);
    end else begin
      chk({tag, "_start_count"}, 64'(start_cnt), 64'd1);
      chk({tag, "_start_lat"}, 64'(start_cyc - req_cyc), 64'd1);
      chk({tag, "_first_rd_lat"}, 64'(first_rd - req_cyc), 64'd1);
      chk({tag, "_first_valid_lat"}, 64'(first_val - req_cyc), 64'd2);
      chk({tag, "_done_after_cap"}, 64'(done_cyc - cap_cyc), 64'd1);
      if (!j.rnd) chk({tag, "_stream_span"}, 64'(last_fire - first_val + 1), 64'(j.words + 1));
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({p, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({p, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({p, "_core_start"}, 64'(core_start), 64'd0);
    chk({p, "_core_valid_i"}, 64'(core_valid_i), 64'd0);
    chk({p, "_core_data_i"}, core_data_i, 64'd0);
    chk({p, "_core_ready_o"}, 64'(core_ready_o), 64'd0);
    chk({p, "_done"}, 64'(done), 64'd0);
    chk({p, "_accept"}, 64'(accept), 64'd0);
    chk({p, "_err"}, 64'(err), 64'd0);
    chk({p, "_cycles"}, 64'(cycles), 64'd0);
    chk({p, "_core_sec_lvl"}, 64'(core_sec_lvl), 64'd0);
  endtask

  initial begin
    job_t rj, cj;
    rst_n = 1'b0; req_valid = 1'b0; req_base = '0; req_sec_lvl = '0;
    core_valid_o = 1'b0; core_data_o = '0;
    //          lvl     mlen    base      result                  rnd  dly words acc err
    jobs[0] = '{3'b010, 32'd33,  16'h0100, 64'h0,                  1'b0, 0, 473, 1'b1, 1'b0};
    jobs[1] = '{3'b101, 32'd0,   16'h2000, 64'h1,                  1'b0, 0, 900, 1'b0, 1'b0};
    jobs[2] = '{3'b011, 32'd100, 16'hFE80, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 3, 670, 1'b1, 1'b0};
    jobs[3] = '{3'b100, 32'd0,   16'h1234, 64'h0,                  1'b0, 0, 0,   1'b0, 1'b1};
    jobs[4] = '{3'b010, 32'd8,   16'h4000, 64'h3,                  1'b1, 0, 469, 1'b0, 1'b0};
    jobs[5] = '{3'b000, 32'd5,   16'h0010, 64'h0,                  1'b0, 0, 0,   1'b0, 1'b1};
    jobs[6] = '{3'b101, 32'd65,  16'h8000, 64'h0,                  1'b1, 5, 909, 1'b1, 1'b0};
    jobs[7] = '{3'b011, 32'd1,   16'hFFFF, 64'h2,                  1'b0, 2, 658, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      launch_job(jobs[k]);
      finish_job(jobs[k], $sformatf("job%0d", k));
    end

    // Asynchronous reset in the middle of z, then a fresh lvl2 job
    rj = '{3'b010, 32'd16, 16'h6000, 64'h0, 1'b0, 0, 470, 1'b1, 1'b0};
    launch_job(rj);
    for (int n = 0; n < 200 && stream_cnt < 20; n++) begin @(posedge clk); #1; end
    chk("rst_mid_z_reached", 64'(stream_cnt >= 20), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    launch_job(rj);
    finish_job(rj, "after_rst");

    // Result held off for 1000 cycles after the last h word
    cj = '{3'b010, 32'd33, 16'h0300, 64'h0, 1'b0, 1000, 473, 1'b1, 1'b0};
    launch_job(cj);
    finish_job(cj, "hold1000");
    chk("hold1000_cap_gap", 64'(cap_cyc - last_fire), 64'd1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
